// File: rtl/memory_pkg.sv
// memory_pkg: shared definitions for the byte-serial memory interface.
//   - access-size codes carried on the Type port
//   - read/write codes carried on the RW port
//   - FSM state encoding used by memory_interface
//   - helpers for byte count, write-data alignment and misalignment detection
package memory_pkg;

  // 2'b11 is not named; it is handled as a word access.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } type_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  function automatic logic [2:0] byte_count(input logic [1:0] t);
    case (t)
      BYTE:    byte_count = 3'd1;
      HALF:    byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  // Left-justify the active slice so the first byte to send is always [31:24].
  function automatic logic [31:0] align_wdata(input logic [1:0] t, input logic [31:0] d);
    case (t)
      BYTE:    align_wdata = {d[7:0], 24'h0};
      HALF:    align_wdata = {d[15:0], 16'h0};
      default: align_wdata = d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a_lo);
    case (t)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = a_lo[0];
      default: misaligned = (a_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: byte-wide storage for memory_interface.
// The array is named Mem so a testbench can preload or inspect it hierarchically.
// Ports:
//   i_clk    - clock, write port is synchronous to its rising edge
//   i_we     - write enable
//   i_waddr  - write byte address
//   i_wdata  - write byte
//   i_raddr  - read byte address (asynchronous read)
//   o_rdata  - read byte
module mem_byte_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [7:0]            o_rdata
);

  logic [7:0] Mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      Mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = Mem[i_raddr];

endmodule

// File: rtl/memory_interface.sv
// memory_interface: request/complete handshake front end that moves 1, 2 or 4
// bytes big-endian between a 32-bit data bus and a byte-wide memory, one byte
// per transfer slot, with WAIT_CYCLES stall edges before every byte.
// Optional build macro: MEM_ALIGN_CHECK_EN -- when defined, misaligned
// halfword/word requests complete immediately with ERR=1 and no memory access;
// when undefined, misaligned requests run normally and ERR is held at 0.
// Ports:
//   CLK      - clock, all state changes on rising edge
//   Reset    - synchronous active-high reset (memory contents are kept)
//   MFA      - request level, held high until MFC is seen
//   RW       - 1 write, 0 read
//   Type     - 00 byte, 01 halfword, 10/11 word
//   Address  - byte address of the most significant byte
//   DataIn   - write data, right-justified
//   DataOut  - read data, zero-extended, registered
//   MFC      - access complete, registered
//   ERR      - misaligned-access flag, registered
//
// state  | meaning
// IDLE   | waiting for MFA; request fields captured on acceptance
// ACCESS | stall WAIT_CYCLES edges, then move one byte, until all bytes done
// DONE   | first edge raises MFC (and ERR); then hold until MFA seen low
module memory_interface
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  MFA,
  input  logic                  RW,
  input  logic [1:0]            Type,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC,
  output logic                  ERR
);

  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES);

  state_e                r_state;
  logic                  r_rw;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_bytes_left;
  logic [WCW-1:0]        r_wait;
  logic [31:0]           r_dout;
  logic                  r_mfc;
`ifdef MEM_ALIGN_CHECK_EN
  logic                  r_err;
  logic                  r_bad;
`endif

  logic                  w_xfer;
  logic                  w_we;
  logic [7:0]            w_rdata;

  // A byte moves on every edge of ACCESS where the stall counter has expired.
  assign w_xfer = (r_state == ACCESS) && (r_wait == '0);
  // Reset wins over a pending write so an abandoned access stops cleanly.
  assign w_we   = w_xfer && (r_rw == WRITE) && !Reset;

  mem_byte_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata[31:24]),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_bytes_left <= '0;
      r_wait       <= '0;
      r_dout       <= '0;
      r_mfc        <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      r_err        <= 1'b0;
      r_bad        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (MFA) begin
            r_rw         <= RW;
            r_addr       <= Address;
            r_wdata      <= align_wdata(Type, DataIn);
            r_bytes_left <= byte_count(Type);
            r_wait       <= WAIT_LOAD;
            r_dout       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned(Type, Address[1:0])) begin
              r_bad   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_bad   <= 1'b0;
              r_state <= ACCESS;
            end
`else
            r_state      <= ACCESS;
`endif
          end
        end

        ACCESS: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WCW'(1);
          end else begin
            r_wait       <= WAIT_LOAD;
            r_addr       <= r_addr + ADDR_WIDTH'(1);
            r_wdata      <= {r_wdata[23:0], 8'h00};
            r_bytes_left <= r_bytes_left - 3'd1;
            if (r_rw == READ) begin
              r_dout <= {r_dout[23:0], w_rdata};
            end
            if (r_bytes_left == 3'd1) begin
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          // MFC rises on the first DONE edge, giving the extra completion edge.
          if (!r_mfc) begin
            r_mfc <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            r_err <= r_bad;
`endif
          end else if (!MFA) begin
            r_mfc   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_err   <= 1'b0;
`endif
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign DataOut = r_dout;
  assign MFC     = r_mfc;
`ifdef MEM_ALIGN_CHECK_EN
  assign ERR     = r_err;
`else
  assign ERR     = 1'b0;
`endif

endmodule
